// File: rtl/mips_commit_checker.sv
// Commit-stream checker: compares each register-file writeback of the core against a loadable
// table of expected (dest, value) pairs and reports pass/fail counts, first failure and stall timeout.
module mips_commit_checker #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned IDX_W        = $clog2(DEPTH),
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 1024,
    parameter bit          CHECK_DEST   = 1'b1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en_i,
    input  logic [IDX_W-1:0]  load_idx_i,
    input  logic [4:0]        load_dest_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [IDX_W:0]    num_checks_i,
    input  logic              start_i,
    input  logic              commit_valid_i,
    input  logic [4:0]        commit_dest_i,
    input  logic [DATA_W-1:0] commit_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              all_pass_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  pass_count_o,
    output logic [CNT_W-1:0]  fail_count_o,
    output logic              first_fail_vld_o,
    output logic [IDX_W-1:0]  first_fail_idx_o,
    output logic [DATA_W-1:0] first_fail_data_o
);
    localparam int unsigned NUM_W   = IDX_W + 1;
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CMP_W   = (CNT_W > NUM_W) ? CNT_W : NUM_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic               ffv_q, ffv_d;
    logic [IDX_W-1:0]   ffidx_q, ffidx_d;
    logic [DATA_W-1:0]  ffdata_q, ffdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               all_pass_q, all_pass_d;
    logic               match;
    logic               last_cmp;

    logic [4:0]         tbl_dest_q [DEPTH];
    logic [DATA_W-1:0]  tbl_data_q [DEPTH];

    // Expected table: not reset, writable whenever no run is in progress
    always_ff @(posedge clk) begin
        if (load_en_i && (state_q != S_RUN)) begin
            tbl_dest_q[load_idx_i] <= load_dest_i;
            tbl_data_q[load_idx_i] <= load_data_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        stall_d   = stall_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        ffv_d     = ffv_q;
        ffidx_d   = ffidx_q;
        ffdata_d  = ffdata_q;
        match     = (commit_data_i == tbl_data_q[idx_q]) &&
                    (!CHECK_DEST || (commit_dest_i == tbl_dest_q[idx_q]));
        last_cmp  = ({1'b0, idx_q} == (num_q - NUM_W'(1)));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i && (num_checks_i != '0)) begin
                    state_d   = S_RUN;
                    idx_d     = '0;
                    num_d     = num_checks_i;
                    stall_d   = '0;
                    pass_d    = '0;
                    fail_d    = '0;
                    timeout_d = 1'b0;
                    ffv_d     = 1'b0;
                    ffidx_d   = '0;
                    ffdata_d  = '0;
                end
            end
            S_RUN: begin
                if (commit_valid_i) begin
                    stall_d = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    if (match) begin
                        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                        if (!ffv_q) begin
                            ffv_d    = 1'b1;
                            ffidx_d  = idx_q;
                            ffdata_d = commit_data_i;
                        end
                    end
                    if (last_cmp || (STOP_ON_FAIL && !match)) state_d = S_DONE;
                end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they align with the counters
        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        all_pass_d = done_d && (fail_d == '0) && !timeout_d &&
                     (CMP_W'(pass_d) == CMP_W'(num_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            stall_q    <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            timeout_q  <= 1'b0;
            ffv_q      <= 1'b0;
            ffidx_q    <= '0;
            ffdata_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            all_pass_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            stall_q    <= stall_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            ffv_q      <= ffv_d;
            ffidx_q    <= ffidx_d;
            ffdata_q   <= ffdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            all_pass_q <= all_pass_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign all_pass_o        = all_pass_q;
    assign timeout_o         = timeout_q;
    assign pass_count_o      = pass_q;
    assign fail_count_o      = fail_q;
    assign first_fail_vld_o  = ffv_q;
    assign first_fail_idx_o  = ffidx_q;
    assign first_fail_data_o = ffdata_q;

endmodule

// File: tb/tb_mips_commit_checker.sv
// Bench for mips_commit_checker: two configurations share one stimulus stream; a scoreboard per
// instance holds the expected end-of-run result, popped by a monitor when done rises.
module tb_mips_commit_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [4:0]  load_idx;
    logic [4:0]  load_dest;
    logic [31:0] load_data;
    logic [5:0]  num_checks;
    logic        start;
    logic        cv;
    logic [4:0]  cd;
    logic [31:0] cx;

    logic a_busy, a_done, a_ap, a_to, a_ffv;
    logic [15:0] a_pass, a_fail;
    logic [4:0]  a_ffidx;
    logic [31:0] a_ffdata;
    logic b_busy, b_done, b_ap, b_to, b_ffv;
    logic [2:0]  b_pass, b_fail;
    logic [4:0]  b_ffidx;
    logic [31:0] b_ffdata;

    always #5 clk = ~clk;

    // A: dest+data compare, short timeout. B: data only, stop on fail, 3-bit saturating counters.
    mips_commit_checker #(.DATA_W(32), .DEPTH(32), .CNT_W(16), .TIMEOUT(8),
                          .CHECK_DEST(1'b1), .STOP_ON_FAIL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .load_en_i(load_en), .load_idx_i(load_idx),
        .load_dest_i(load_dest), .load_data_i(load_data), .num_checks_i(num_checks),
        .start_i(start), .commit_valid_i(cv), .commit_dest_i(cd), .commit_data_i(cx),
        .busy_o(a_busy), .done_o(a_done), .all_pass_o(a_ap), .timeout_o(a_to),
        .pass_count_o(a_pass), .fail_count_o(a_fail), .first_fail_vld_o(a_ffv),
        .first_fail_idx_o(a_ffidx), .first_fail_data_o(a_ffdata));

    mips_commit_checker #(.DATA_W(32), .DEPTH(32), .CNT_W(3), .TIMEOUT(16),
                          .CHECK_DEST(1'b0), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .load_en_i(load_en), .load_idx_i(load_idx),
        .load_dest_i(load_dest), .load_data_i(load_data), .num_checks_i(num_checks),
        .start_i(start), .commit_valid_i(cv), .commit_dest_i(cd), .commit_data_i(cx),
        .busy_o(b_busy), .done_o(b_done), .all_pass_o(b_ap), .timeout_o(b_to),
        .pass_count_o(b_pass), .fail_count_o(b_fail), .first_fail_vld_o(b_ffv),
        .first_fail_idx_o(b_ffidx), .first_fail_data_o(b_ffdata));

    typedef struct {
        int          npass;
        int          nfail;
        bit          tmo;
        bit          ffv;
        int          ffidx;
        logic [31:0] ffdata;
        bit          ap;
        int          edge_no;
    } exp_t;

    int nchk = 0;
    int nfail = 0;
    int pos_cnt = 0;
    exp_t exp_qa[$];
    exp_t exp_qb[$];
    exp_t last_a, last_b;
    logic [4:0]  tbl_dest [32];
    logic [31:0] tbl_data [32];
    bit          sv[$];
    logic [4:0]  sd[$];
    logic [31:0] sx[$];
    bit          pend_ld = 1'b0;
    logic [4:0]  pend_idx, pend_dest;
    logic [31:0] pend_data;
    logic        a_prev = 1'b0, b_prev = 1'b0;

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: walk the per-cycle commit stream; idle beyond the stream until a timeout fires.
    function automatic exp_t model(input int tmo, input bit chkd, input bit sof,
                                   input int cmax, input int n, input int p0);
        exp_t e;
        int idx, stall;
        bit v, ok;
        e.npass = 0; e.nfail = 0; e.tmo = 0; e.ffv = 0; e.ffidx = 0;
        e.ffdata = 32'd0; e.ap = 0; e.edge_no = -1;
        idx = 0; stall = 0;
        for (int c = 0; c < sv.size() + tmo + 1; c++) begin
            v = (c < sv.size()) ? sv[c] : 1'b0;
            if (v) begin
                stall = 0;
                ok = (sx[c] == tbl_data[idx]) && (!chkd || sd[c] == tbl_dest[idx]);
                if (ok) e.npass = (e.npass < cmax) ? e.npass + 1 : cmax;
                else begin
                    e.nfail = (e.nfail < cmax) ? e.nfail + 1 : cmax;
                    if (!e.ffv) begin e.ffv = 1; e.ffidx = idx; e.ffdata = sx[c]; end
                end
                if (idx == n - 1 || (sof && !ok)) begin e.edge_no = p0 + c + 2; break; end
                idx++;
            end else begin
                stall++;
                if (stall == tmo) begin e.tmo = 1; e.edge_no = p0 + c + 2; break; end
            end
        end
        e.ap = (e.nfail == 0) && !e.tmo && (e.npass == n);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_done && !a_prev) begin
            if (exp_qa.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL a_unexpected_done actual=1 required=0");
            end else begin
                e = exp_qa.pop_front();
                chk("a_done_edge", 64'(pos_cnt), 64'(e.edge_no));
                chk("a_busy", 64'(a_busy), 64'd0);
                chk("a_pass", 64'(a_pass), 64'(e.npass));
                chk("a_fail", 64'(a_fail), 64'(e.nfail));
                chk("a_timeout", 64'(a_to), 64'(e.tmo));
                chk("a_ffv", 64'(a_ffv), 64'(e.ffv));
                chk("a_ffidx", 64'(a_ffidx), 64'(e.ffidx));
                chk("a_ffdata", 64'(a_ffdata), 64'(e.ffdata));
                chk("a_all_pass", 64'(a_ap), 64'(e.ap));
                last_a = e;
            end
        end
        a_prev = a_done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_done && !b_prev) begin
            if (exp_qb.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL b_unexpected_done actual=1 required=0");
            end else begin
                e = exp_qb.pop_front();
                chk("b_done_edge", 64'(pos_cnt), 64'(e.edge_no));
                chk("b_busy", 64'(b_busy), 64'd0);
                chk("b_pass", 64'(b_pass), 64'(e.npass));
                chk("b_fail", 64'(b_fail), 64'(e.nfail));
                chk("b_timeout", 64'(b_to), 64'(e.tmo));
                chk("b_ffv", 64'(b_ffv), 64'(e.ffv));
                chk("b_ffidx", 64'(b_ffidx), 64'(e.ffidx));
                chk("b_ffdata", 64'(b_ffdata), 64'(e.ffdata));
                chk("b_all_pass", 64'(b_ap), 64'(e.ap));
                last_b = e;
            end
        end
        b_prev = b_done;
    end

    task automatic load(input int i, input logic [4:0] d, input logic [31:0] x);
        @(negedge clk);
        load_en = 1'b1; load_idx = 5'(i); load_dest = d; load_data = x;
        tbl_dest[i] = d; tbl_data[i] = x;
    endtask

    task automatic set_pend(input int i, input logic [4:0] d, input logic [31:0] x);
        pend_ld = 1'b1; pend_idx = 5'(i); pend_dest = d; pend_data = x;
        tbl_dest[i] = d; tbl_data[i] = x;
    endtask

    task automatic push(input bit v, input logic [4:0] d, input logic [31:0] x);
        sv.push_back(v); sd.push_back(d); sx.push_back(x);
    endtask

    task automatic push_ok(input int k);
        push(1'b1, tbl_dest[k], tbl_data[k]);
    endtask

    task automatic clr_sched();
        sv.delete(); sd.delete(); sx.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_flags"}, 64'({a_busy, a_done, a_ap, a_to, a_ffv}), 64'd0);
        chk({tag, "_a_counts"}, {a_pass, a_fail, 27'd0, a_ffidx}, 64'd0);
        chk({tag, "_a_ffdata"}, 64'(a_ffdata), 64'd0);
        chk({tag, "_b_flags"}, 64'({b_busy, b_done, b_ap, b_to, b_ffv}), 64'd0);
        chk({tag, "_b_counts"}, 64'({b_pass, b_fail, b_ffidx, b_ffdata}), 64'd0);
    endtask

    // Start a run of n checks and drive the prepared commit stream; junk=1 also tries a load mid-run.
    task automatic run_sched(input int n, input bit junk);
        exp_t ea, eb;
        int p0, budget;
        @(negedge clk);
        num_checks = 6'(n); start = 1'b1;
        load_en = pend_ld; load_idx = pend_idx; load_dest = pend_dest; load_data = pend_data;
        pend_ld = 1'b0;
        p0 = pos_cnt;
        ea = model(8, 1'b1, 1'b0, 65535, n, p0);
        eb = model(16, 1'b0, 1'b1, 7, n, p0);
        exp_qa.push_back(ea);
        exp_qb.push_back(eb);
        for (int c = 0; c < sv.size(); c++) begin
            @(negedge clk);
            start = 1'b0;
            load_en = junk && (c == 0);
            if (junk && c == 0) begin
                load_idx = 5'(n - 1); load_dest = ~tbl_dest[n-1]; load_data = ~tbl_data[n-1];
            end
            cv = sv[c]; cd = sd[c]; cx = sx[c];
        end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0; cv = 1'b0;
        budget = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
            nchk++; nfail++;
            $display("FAIL run_done_wait actual=pending required=done (a=%0d b=%0d)",
                     exp_qa.size(), exp_qb.size());
            exp_qa.delete(); exp_qb.delete();
        end else begin
            chk("a_hold", {a_done, 15'd0, a_pass, a_fail, 16'd0}, {1'b1, 15'd0, 16'(ea.npass), 16'(ea.nfail), 16'd0});
            chk("b_hold", 64'({b_done, b_pass, b_fail}), 64'({1'b1, 3'(eb.npass), 3'(eb.nfail)}));
        end
    endtask

    task automatic gen_random(input int n);
        int r, g;
        clr_sched();
        for (int k = 0; k < n + 2; k++) begin
            r = $urandom_range(0, 99);
            g = (r < 10) ? $urandom_range(10, 20) : $urandom_range(0, 2);
            repeat (g) push(1'b0, 5'd0, 32'd0);
            if (k >= n) push(1'b1, 5'($urandom), $urandom);
            else begin
                r = $urandom_range(0, 9);
                if (r < 7) push_ok(k);
                else if (r < 9) push(1'b1, tbl_dest[k], tbl_data[k] ^ 32'($urandom_range(1, 65535)));
                else push(1'b1, tbl_dest[k] + 5'd1, tbl_data[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; load_en = 1'b0; load_idx = '0; load_dest = '0; load_data = '0;
        num_checks = '0; start = 1'b0; cv = 1'b0; cd = '0; cx = '0;
        pend_idx = '0; pend_dest = '0; pend_data = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // T1: all match, last entry written together with start
        load(0, 5'd1, 32'h5); load(1, 5'd2, 32'hA); load(2, 5'd3, 32'hF);
        set_pend(3, 5'd4, 32'hFFFF_FFFF);
        clr_sched(); push_ok(0); push_ok(1); push(1'b0, 5'd0, 32'd0); push_ok(2); push_ok(3);
        run_sched(4, 1'b1);

        // start with num_checks=0 while DONE: results held
        @(negedge clk); start = 1'b1; num_checks = 6'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("done_hold_num0", 64'({a_done, a_busy, a_pass}), 64'({1'b1, 1'b0, 16'(last_a.npass)}));

        // T2: third commit wrong data
        clr_sched(); push_ok(0); push_ok(1); push(1'b1, 5'd3, 32'hE); push_ok(3);
        run_sched(4, 1'b0);

        // T3: mismatch at idx 1, later commits must not count in stop-on-fail instance
        clr_sched(); push_ok(0); push(1'b1, 5'd2, 32'hB); push_ok(2); push_ok(3);
        run_sched(4, 1'b0);

        // T4: two commits then stall
        clr_sched(); push_ok(0); push_ok(1);
        run_sched(4, 1'b0);

        // T5: right data to wrong register
        clr_sched(); push_ok(0); push_ok(1); push(1'b1, 5'd9, 32'hF); push_ok(3);
        run_sched(4, 1'b0);

        // Full table depth; counters of B saturate
        for (int i = 0; i < 32; i++) load(i, 5'($urandom), $urandom);
        clr_sched();
        for (int i = 0; i < 32; i++) push_ok(i);
        run_sched(32, 1'b0);

        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) load(i, 5'($urandom), $urandom);
            if ($urandom_range(0, 1) == 1) set_pend($urandom_range(0, n - 1), 5'($urandom), $urandom);
            gen_random(n);
            run_sched(n, ($urandom_range(0, 2) == 0));
        end

        // T6: asynchronous reset mid-run, then start with num_checks=0 from IDLE
        @(negedge clk); num_checks = 6'd4; start = 1'b1; load_en = 1'b0;
        @(negedge clk); start = 1'b0; cv = 1'b1; cd = tbl_dest[0]; cx = tbl_data[0];
        @(negedge clk); cv = 1'b0;
        chk("a_busy_run", 64'({a_busy, a_pass}), 64'({1'b1, 16'd1}));
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1; num_checks = 6'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("idle_num0", 64'({a_busy, a_done, b_busy, b_done}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
